uart_tx_scheduler: RTL and testbench

Sequencer and two-port arbiter for the 10-bit PISO UART transmit shift register (start bit, 8 data bits MSB-first, stop bit).
It arbitrates byte requests from two clients with round-robin priority and generates the baud-rate timing.
It drives the PISO load-select, shift strobe and parallel data.
It returns per-client acknowledge and frame-complete pulses, and sits between the protocol clients and the PISO register on the TX line.

---
 rtl/uart_tx_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - two-client round-robin sequencer and baud timer for a 10-bit UART PISO
//
// Arbitrates byte requests from two clients and sequences one UART frame at a
// time through an external 10-bit parallel-in/serial-out register. The frame
// is start bit (0), 8 data bits MSB first, stop bit (1).
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit period (>= 2)
//   FRAME_BITS    bits per frame on the line; fixed at 10
//
// Ports
//   pulse        system clock, rising edge
//   reset        synchronous active-high reset
//   req0_valid   client 0 has a byte; held until req_ack[0]
//   req0_data    client 0 byte
//   req1_valid   client 1 has a byte; held until req_ack[1]
//   req1_data    client 1 byte
//   req_ack      per-client one-cycle pulse: byte accepted and loaded into the PISO
//   tx_done      per-client one-cycle pulse: that client's frame has left the line
//   busy         high from LOAD through DONE
//   piso_enable  PISO load select (1 = parallel load, 0 = shift)
//   piso_shift   one-cycle strobe: PISO register advances this cycle
//   piso_data    byte presented to the PISO parallel inputs
//   bit_index    bit currently on the line (0 = start, 1..8 = data, 9 = stop)
module uart_tx_scheduler #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FRAME_BITS   = 10
) (
    input  logic       pulse,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic [1:0] req_ack,
    output logic [1:0] tx_done,
    output logic       busy,
    output logic       piso_enable,
    output logic       piso_shift,
    output logic [7:0] piso_data,
    output logic [3:0] bit_index
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       STOP_BIT = 4'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             grant;       // client owning the frame in flight
    logic             last_grant;  // client served most recently
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       data_q;      // byte captured at LOAD, held for the frame

    logic             any_req;
    logic             arb_pick;
    logic             baud_tick;

    assign any_req = req0_valid | req1_valid;

    // A lone requester always wins; under contention the client that was
    // not served last wins, so neither client can starve the other.
    assign arb_pick = (req0_valid & req1_valid) ? ~last_grant : req1_valid;

    assign baud_tick = (state == SEND) && (baud_cnt == CNT_LAST);

    assign bit_index = bit_cnt;

    always_ff @(posedge pulse) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        req_ack     = 2'b00;
        tx_done     = 2'b00;
        busy        = 1'b0;
        piso_enable = 1'b0;
        piso_shift  = 1'b0;
        piso_data   = 8'h00;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // The load strobe doubles as the shift strobe so the PISO
                // captures the whole frame on the edge that ends this cycle.
                busy        = 1'b1;
                req_ack     = grant ? 2'b10 : 2'b01;
                piso_enable = 1'b1;
                piso_shift  = 1'b1;
                piso_data   = grant ? req1_data : req0_data;
                state_next  = SEND;
            end
            SEND: begin
                busy      = 1'b1;
                piso_data = data_q;
                if (baud_tick) begin
                    // The stop bit is already on the line once bit 9 is
                    // reached; its period ends without a shift so the line
                    // stays high into the next frame.
                    if (bit_cnt == STOP_BIT) begin
                        state_next = DONE;
                    end else begin
                        piso_shift = 1'b1;
                    end
                end
            end
            DONE: begin
                busy       = 1'b1;
                tx_done    = grant ? 2'b10 : 2'b01;
                piso_data  = data_q;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge pulse) begin
        if (reset) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= 4'd0;
            data_q     <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= 4'd0;
                    if (any_req) begin
                        grant <= arb_pick;
                    end
                end
                LOAD: begin
                    data_q     <= piso_data;
                    last_grant <= grant;
                    baud_cnt   <= '0;
                    bit_cnt    <= 4'd0;
                end
                SEND: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        if (bit_cnt != STOP_BIT) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DONE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= 4'd0;
                end
                default: begin
                    baud_cnt <= '0;
                    bit_cnt  <= 4'd0;
                end
            endcase
        end
    end

    // At most one acknowledge or completion strobe is ever active, and the
    // bit position never runs past the stop bit.
    always_ff @(posedge pulse) begin
        if (!reset) begin
            assert ($onehot0({req_ack, tx_done}));
            assert (bit_cnt <= STOP_BIT);
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - scoreboard bench for uart_tx_scheduler at CLKS_PER_BIT 4 and 2
module tb_uart_tx_scheduler;

    logic pulse = 1'b0;
    always #5 pulse = ~pulse;

    typedef struct {
        int          cyc;
        logic [17:0] ev;   // {req_ack, tx_done, piso_shift, piso_enable, piso_data, bit_index}
    } exp_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int n, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (CLKS_PER_BIT=%0d) at %0t: got %h, expected %h", name, n, $time, got, exp);
        end
    endtask

    function automatic logic [17:0] mk_ev(input logic [1:0] a, input logic [1:0] d, input logic s,
                                          input logic e, input logic [7:0] dat, input logic [3:0] b);
        return {a, d, s, e, dat, b};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int N = (g == 0) ? 4 : 2;

        logic       rst = 1'b1;
        logic       v0 = 1'b0;
        logic       v1 = 1'b0;
        logic [7:0] d0 = 8'h00;
        logic [7:0] d1 = 8'h00;
        logic [1:0] ack;
        logic [1:0] done;
        logic       busy;
        logic       en;
        logic       sh;
        logic [7:0] pdata;
        logic [3:0] bidx;

        int         cyc = 0;
        int         idle_from = 0;
        int         last = 1;
        bit         armed = 1'b0;
        bit         rst_chk = 1'b0;
        bit         fin = 1'b0;
        int         f_start = 0;
        logic [7:0] f_data = 8'h00;
        bit         f_valid = 1'b0;
        int         busy_lo = -1;
        int         busy_hi = -2;
        logic [9:0] piso = 10'h3ff;
        exp_t       q[$];

        uart_tx_scheduler #(.CLKS_PER_BIT(N)) dut (
            .pulse      (pulse),
            .reset      (rst),
            .req0_valid (v0),
            .req0_data  (d0),
            .req1_valid (v1),
            .req1_data  (d1),
            .req_ack    (ack),
            .tx_done    (done),
            .busy       (busy),
            .piso_enable(en),
            .piso_shift (sh),
            .piso_data  (pdata),
            .bit_index  (bidx)
        );

        // Reference model: a frame granted at period P acks at P, shifts at
        // P+k*N for k = 1..9, completes at P+1+10N, and the scheduler is free
        // to arbitrate again from P+2+10N.
        initial begin
            forever begin
                @(posedge pulse);
                cyc++;
                if (rst) begin
                    q.delete();
                    idle_from = cyc;
                    last      = 1;
                    f_valid   = 1'b0;
                    busy_lo   = -1;
                    busy_hi   = -2;
                    armed     = 1'b1;
                    rst_chk   = 1'b1;
                end else if (armed && (cyc - 1 >= idle_from) && (v0 || v1)) begin
                    int         w;
                    logic [7:0] dat;
                    w    = (v0 && v1) ? 1 - last : (v1 ? 1 : 0);
                    last = w;
                    dat  = (w == 1) ? d1 : d0;
                    q.push_back('{cyc, mk_ev(2'(1 << w), 2'b00, 1'b1, 1'b1, dat, 4'd0)});
                    for (int k = 1; k <= 9; k++) begin
                        q.push_back('{cyc + k * N, mk_ev(2'b00, 2'b00, 1'b1, 1'b0, dat, 4'(k - 1))});
                    end
                    q.push_back('{cyc + 1 + 10 * N, mk_ev(2'b00, 2'(1 << w), 1'b0, 1'b0, 8'h00, 4'h0)});
                    idle_from = cyc + 2 + 10 * N;
                    f_start   = cyc;
                    f_data    = dat;
                    f_valid   = 1'b1;
                    busy_lo   = cyc;
                    busy_hi   = cyc + 1 + 10 * N;
                end
            end
        end

        // PISO register driven by the DUT strobes; bit 9 is the TX line.
        initial begin
            forever begin
                @(posedge pulse);
                if (rst) begin
                    piso = 10'h3ff;
                end else if (sh && en) begin
                    piso = {1'b0, pdata, 1'b1};
                end else if (sh) begin
                    piso = {piso[8:0], 1'b1};
                end
            end
        end

        // Monitor
        initial begin
            forever begin
                @(negedge pulse);
                if (armed) begin
                    logic [17:0] got;
                    logic        exp_line;
                    int          j;
                    exp_t        e;
                    if (rst_chk) begin
                        check("reset_outputs", N, 32'({ack, done, busy, en, sh, pdata, bidx}), 32'd0);
                        rst_chk = 1'b0;
                    end
                    check("busy", N, 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
                    exp_line = 1'b1;
                    if (f_valid && cyc > f_start && cyc <= f_start + 10 * N) begin
                        j = (cyc - f_start - 1) / N;
                        if (j == 0) begin
                            exp_line = 1'b0;
                        end else if (j < 9) begin
                            exp_line = f_data[8 - j];
                        end
                    end
                    check("tx_line", N, 32'(piso[9]), 32'(exp_line));
                    if (ack != 2'b00 || done != 2'b00 || sh || en) begin
                        got = (done != 2'b00) ? {ack, done, sh, en, 12'h000} : {ack, done, sh, en, pdata, bidx};
                        if (q.size() == 0) begin
                            check("unexpected_event", N, 32'(got), 32'd0);
                        end else begin
                            e = q.pop_front();
                            check("event_cycle", N, 32'(cyc), 32'(e.cyc));
                            check("event_value", N, 32'(got), 32'(e.ev));
                        end
                    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                        e = q.pop_front();
                        check("missing_event", N, 32'({ack, done, sh, en}), 32'(e.ev[17:12]));
                    end
                end
            end
        end

        // Called at a falling edge; returns at the falling edge after the ack.
        task automatic send(input int c, input logic [7:0] d);
            bit seen;
            seen = 1'b0;
            if (c == 0) begin
                v0 = 1'b1;
                d0 = d;
            end else begin
                v1 = 1'b1;
                d1 = d;
            end
            for (int i = 0; i < 30 * N + 40 && !seen; i++) begin
                @(negedge pulse);
                seen = ack[c];
            end
            check("ack_wait", N, 32'(ack[c]), 32'd1);
            @(negedge pulse);
            if (c == 0) begin
                v0 = 1'b0;
            end else begin
                v1 = 1'b0;
            end
        endtask

        task automatic settle();
            int i;
            i = 0;
            while ((q.size() != 0 || busy) && i < 40 * N + 100) begin
                @(negedge pulse);
                i++;
            end
            check("settle", N, 32'(busy), 32'd0);
            repeat (2) @(negedge pulse);
        endtask

        initial begin
            repeat (3) @(negedge pulse);
            rst = 1'b0;
            repeat (2) @(negedge pulse);

            send(0, 8'hAA);
            settle();

            fork
                send(0, 8'h11);
                send(1, 8'h22);
            join
            settle();

            fork
                begin
                    send(0, 8'($urandom));
                    send(0, 8'($urandom));
                end
                begin
                    send(1, 8'($urandom));
                    send(1, 8'($urandom));
                end
            join
            settle();

            send(0, 8'($urandom));
            for (int i = 0; i < 10 * N && bidx != 4'd5; i++) @(negedge pulse);
            check("reach_bit5", N, 32'(bidx), 32'd5);
            rst = 1'b1;
            @(negedge pulse);
            rst = 1'b0;
            @(negedge pulse);
            send(1, 8'h5C);
            settle();

            send(0, 8'($urandom));
            repeat (N) @(negedge pulse);
            v1 = 1'b1;
            d1 = 8'($urandom);
            @(negedge pulse);
            v1 = 1'b0;
            settle();

            fork
                begin
                    repeat (6) begin
                        repeat ($urandom_range(0, 12 * N)) @(negedge pulse);
                        send(0, 8'($urandom));
                    end
                end
                begin
                    repeat (6) begin
                        repeat ($urandom_range(0, 12 * N)) @(negedge pulse);
                        send(1, 8'($urandom));
                    end
                end
            join
            settle();
            fin = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(u[0].fin && u[1].fin) && t < 60000) begin
            @(negedge pulse);
            t++;
        end
        check("run_complete", 0, 32'(u[0].fin && u[1].fin), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
